ucc_result_fifo: RTL and testbench
==================================

Name: ucc_result_fifo

Overview:
- Downstream stage of the combinational UCC converter.
- Captures each converted word, its error flag, and the selin/selout tags on a valid/ready handshake, then buffers them in a small FIFO.
- Presents the buffered words to the consumer (display/serial layer) on a second valid/ready interface.
- Keeps a saturating count of conversion errors.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DW, 8, converted word width; matches UCC out.
- ECW, 8, error counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  stage can accept.
- conv_out  input  DW  converted word from UCC.
- conv_err  input  1  UCC errors flag for this word.
- conv_selin  input  2  input-code select used.
- conv_selout  input  2  output-code select used.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head.
- out_word  output  DW  head word.
- out_err  output  1  head error flag.
- out_selin  output  2  head selin tag.
- out_selout  output  2  head selout tag.
- level  output  clog2(DEPTH)+1  occupied entries.
- err_count  output  ECW  saturating error count.
- clr_err  input  1  synchronous clear of err_count.

Behaviour:
- Reset (asynchronous, rst_n=0): read/write pointers=0, level=0, out_valid=0, err_count=0.
  - out_word/out_err/out_selin/out_selout read 0, since storage is cleared.
  - in_ready=1 once level=0.
- Reset asserted mid-operation flushes all entries immediately; no partial pop is reported.
- Push: in_valid&&in_ready. Pop: out_valid&&out_ready.
- in_ready = (level != DEPTH), combinational from registered level. It does not depend on out_ready (no full-pass-through).
- out_valid = (level != 0). Outputs are driven from the head entry (first-word-fall-through).
- Latency: a word pushed at edge N is visible on out_* after edge N. There is no empty bypass: push with level=0 gives out_valid=1 in the next cycle only.
- Simultaneous push and pop, 0<level<DEPTH: level unchanged, both pointers advance.
- Full: in_ready=0, a presented word is held off, a pop frees one slot next cycle.
- Empty: pop impossible; out_ready is ignored.
- Pointers wrap modulo DEPTH, using an extra MSB for the full/empty distinction.
- Occupancy FSM, registered:
  - States: EMPTY, PARTIAL, FULL.
  - EMPTY->PARTIAL on push.
  - PARTIAL->FULL on push-only when level=DEPTH-1.
  - PARTIAL->EMPTY on pop-only when level=1.
  - FULL->PARTIAL on pop.
  - Push+pop keeps the current state.
  - in_ready = state!=FULL; out_valid = state!=EMPTY. level must agree with state; the bench checks this.
- err_count: +1 on each push with conv_err=1 and saturates at 2^ECW-1.
  - clr_err=1 sets the count to 0 and wins over a same-cycle increment.
- Tags are stored verbatim; the stage does not validate select codes.

Optional Feature:
- Macro: UCC_DROP_ERR_EN.
- Defined: a push with conv_err=1 is counted in err_count but not written.
  - Pointers, level and FSM are unchanged.
  - The handshake still completes, so in_ready semantics are identical.
- Undefined: error words are stored like any other, with out_err=1.

Decomposition:
- Shared package ucc_pkg holds:
  - code_sel_t (2-bit) typedef.
  - Localparams for the four code encodings, identical to the UCC selin/selout encodings.
  - Packed struct ucc_entry_t {err, selin, selout, word}.
  - Occupancy FSM state enum.
- One sub-module: ucc_fifo_mem.
  - DEPTH x ucc_entry_t register array with write port and asynchronous read port.
  - Reset-clears its contents.
  - All control logic stays in ucc_result_fifo.

Test Plan:
- Reset then push {word=8'h05, err=0, selin=2'b00, selout=2'b01} with out_ready=0 -> next cycle out_valid=1, out_word=8'h05, out_selout=2'b01, level=1.
- Push 8'h01..8'h04 with out_ready=0 -> after 4th push level=4 and in_ready=0. A 5th word 8'h09 is held. Raise out_ready for one cycle -> 8'h01 popped; 8'h09 accepted next cycle; drain order is 02,03,04,09.
- At level=2, hold in_valid=1 and out_ready=1 for 10 cycles with incrementing words -> level stays 2 and output order is strictly FIFO, including across pointer wrap.
- Push 3 words with conv_err=1 -> err_count=3. Assert clr_err together with a 4th error push -> err_count=0.
  - With ECW=2, push 5 error words -> err_count saturates at 3.
- Build with UCC_DROP_ERR_EN: push err=0 (8'h10), err=1 (8'h11), err=0 (8'h12) -> out delivers 8'h10 then 8'h12, level peaks at 2, err_count=1.
- Assert rst_n=0 asynchronously mid-cycle at level=3 -> out_valid=0, level=0, err_count=0 without waiting for a clock edge; in_ready=1 after release.

Source files
------------

// File: rtl/ucc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ucc_pkg
//  Purpose  : Shared types for the UCC result stage: code-select type and
//             encodings, the buffered entry record and the occupancy states.
//  Revision : 1.0  initial release
// ============================================================================
package ucc_pkg;

    // Word width produced by the UCC converter; the entry record is sized by it.
    localparam int UCC_DW = 8;

    typedef logic [1:0] code_sel_t;

    // Code encodings shared with the converter's selin/selout inputs.
    localparam code_sel_t CODE_BIN  = 2'b00;
    localparam code_sel_t CODE_BCD  = 2'b01;
    localparam code_sel_t CODE_GRAY = 2'b10;
    localparam code_sel_t CODE_XS3  = 2'b11;

    typedef struct packed {
        logic              err;
        code_sel_t         selin;
        code_sel_t         selout;
        logic [UCC_DW-1:0] word;
    } ucc_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

endpackage
`default_nettype wire

// File: rtl/ucc_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : ucc_fifo_mem
//  Purpose  : DEPTH x ucc_entry_t register file, one synchronous write port and
//             one asynchronous read port. Contents clear on reset.
//  Ports    : clk, rst_n    clock / async active-low reset
//             we, waddr, wdata   write port
//             raddr, rdata       combinational read port
//  Revision : 1.0  initial release
// ============================================================================
module ucc_fifo_mem
    import ucc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  ucc_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output ucc_entry_t    rdata
);

    ucc_entry_t r_mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[gi] <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    r_mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/ucc_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ucc_result_fifo
//  Purpose  : Captures converted words plus error flag and select tags from the
//             UCC converter, buffers them in a first-word-fall-through FIFO and
//             keeps a saturating count of conversion errors.
//  Ports    : clk, rst_n                 clock / async active-low reset
//             in_valid, in_ready          upstream handshake
//             conv_out/err/selin/selout   captured word and tags
//             out_valid, out_ready        downstream handshake
//             out_word/err/selin/selout   head entry
//             level                       occupied entries
//             err_count, clr_err          saturating error counter / clear
//  Config   : `define UCC_DROP_ERR_EN to count error words without storing them.
//  Note     : DW must equal ucc_pkg::UCC_DW, the width of the stored record.
//  Revision : 1.0  initial release
// ============================================================================
module ucc_result_fifo
    import ucc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int ECW   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            conv_out,
    input  logic                     conv_err,
    input  logic [1:0]               conv_selin,
    input  logic [1:0]               conv_selout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_word,
    output logic                     out_err,
    output logic [1:0]               out_selin,
    output logic [1:0]               out_selout,
    output logic [$clog2(DEPTH):0]   level,
    output logic [ECW-1:0]           err_count,
    input  logic                     clr_err
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    C_LVL_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]    C_LVL_ONE  = (AW+1)'(1);
    localparam logic [ECW-1:0] C_ERR_MAX  = {ECW{1'b1}};

    logic [AW:0]    r_wptr;
    logic [AW:0]    r_rptr;
    occ_state_t     r_state;
    occ_state_t     w_state_nxt;
    logic [ECW-1:0] r_err_count;
    logic [AW:0]    w_level;
    logic           w_push;
    logic           w_pop;
    logic           w_wr;
    ucc_entry_t     w_wdata;
    ucc_entry_t     w_rdata;

    // Extra pointer MSB makes the difference a true occupancy (0..DEPTH).
    assign w_level   = r_wptr - r_rptr;
    assign level     = w_level;

    assign in_ready  = (r_state != OCC_FULL);
    assign out_valid = (r_state != OCC_EMPTY);

    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

`ifdef UCC_DROP_ERR_EN
    // Error words complete the handshake but never occupy a slot.
    assign w_wr = w_push && !conv_err;
`else
    assign w_wr = w_push;
`endif

    assign w_wdata = '{err: conv_err, selin: conv_selin, selout: conv_selout, word: conv_out};

    ucc_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_wr),
        .waddr (r_wptr[AW-1:0]),
        .wdata (w_wdata),
        .raddr (r_rptr[AW-1:0]),
        .rdata (w_rdata)
    );

    assign out_word   = w_rdata.word;
    assign out_err    = w_rdata.err;
    assign out_selin  = w_rdata.selin;
    assign out_selout = w_rdata.selout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Occupancy FSM; a simultaneous write and pop leaves the state alone.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OCC_EMPTY: begin
                if (w_wr) begin
                    w_state_nxt = OCC_PARTIAL;
                end
            end
            OCC_PARTIAL: begin
                if (w_wr && !w_pop && (w_level == C_LVL_LAST)) begin
                    w_state_nxt = OCC_FULL;
                end else if (w_pop && !w_wr && (w_level == C_LVL_ONE)) begin
                    w_state_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (w_pop) begin
                    w_state_nxt = OCC_PARTIAL;
                end
            end
            default: w_state_nxt = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear wins over a same-cycle increment; count holds at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (clr_err) begin
            r_err_count <= '0;
        end else if (w_push && conv_err && (r_err_count != C_ERR_MAX)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ucc_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ucc_result_fifo
//  Purpose  : Self-checking bench for ucc_result_fifo (DEPTH=4). A second
//             instance with ECW=2 shares the stimulus for counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ucc_result_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] conv_out = 8'h00;
    logic       conv_err = 1'b0;
    logic [1:0] conv_selin = 2'b00;
    logic [1:0] conv_selout = 2'b00;
    logic       out_ready = 1'b0;
    logic       clr_err = 1'b0;

    logic       in_ready, out_valid, out_err;
    logic [7:0] out_word;
    logic [1:0] out_selin, out_selout;
    logic [2:0] level;
    logic [7:0] err_count;

    logic       in_ready2, out_valid2, out_err2;
    logic [7:0] out_word2;
    logic [1:0] out_selin2, out_selout2;
    logic [2:0] level2;
    logic [1:0] err_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ucc_result_fifo #(.DEPTH(4), .DW(8), .ECW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .conv_out(conv_out), .conv_err(conv_err), .conv_selin(conv_selin),
        .conv_selout(conv_selout), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_err(out_err), .out_selin(out_selin),
        .out_selout(out_selout), .level(level), .err_count(err_count),
        .clr_err(clr_err)
    );

    ucc_result_fifo #(.DEPTH(4), .DW(8), .ECW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .conv_out(conv_out), .conv_err(conv_err), .conv_selin(conv_selin),
        .conv_selout(conv_selout), .out_valid(out_valid2), .out_ready(out_ready),
        .out_word(out_word2), .out_err(out_err2), .out_selin(out_selin2),
        .out_selout(out_selout2), .level(level2), .err_count(err_count2),
        .clr_err(clr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake flags must always agree with the occupancy count.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((in_ready !== (level != 3'd4)) || (out_valid !== (level != 3'd0))) begin
                errors++;
                $display("FAIL state_vs_level: in_ready=%0b out_valid=%0b level=%0d",
                         in_ready, out_valid, level);
            end
        end
    end

    typedef struct {
        logic       iv;
        logic       ordy;
        logic [7:0] word;
        logic [1:0] si;
        logic [1:0] so;
        logic       e_ov;
        logic       e_ir;
        logic [7:0] e_word;
        logic [1:0] e_si;
        logic [1:0] e_so;
        logic [2:0] e_lvl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic ordy, logic [7:0] word, logic [1:0] si,
                                logic [1:0] so, logic e_ov, logic e_ir, logic [7:0] e_word,
                                logic [1:0] e_si, logic [1:0] e_so, logic [2:0] e_lvl);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.word = word; v.si = si; v.so = so;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_word = e_word; v.e_si = e_si;
        v.e_so = e_so; v.e_lvl = e_lvl;
        return v;
    endfunction

    initial begin
        //          iv ordy word   si     so     ov ir  head   hsi    hso    lvl
        vecs.push_back(mk(1, 0, 8'h05, 2'b00, 2'b01, 1, 1, 8'h05, 2'b00, 2'b01, 3'd1));
        vecs.push_back(mk(0, 1, 8'h00, 2'b00, 2'b00, 0, 1, 8'h00, 2'b00, 2'b00, 3'd0));
        vecs.push_back(mk(1, 0, 8'h01, 2'b11, 2'b10, 1, 1, 8'h01, 2'b11, 2'b10, 3'd1));
        vecs.push_back(mk(1, 0, 8'h02, 2'b11, 2'b10, 1, 1, 8'h01, 2'b11, 2'b10, 3'd2));
        vecs.push_back(mk(1, 0, 8'h03, 2'b11, 2'b10, 1, 1, 8'h01, 2'b11, 2'b10, 3'd3));
        vecs.push_back(mk(1, 0, 8'h04, 2'b11, 2'b10, 1, 0, 8'h01, 2'b11, 2'b10, 3'd4));
        vecs.push_back(mk(1, 0, 8'h09, 2'b11, 2'b10, 1, 0, 8'h01, 2'b11, 2'b10, 3'd4));
        vecs.push_back(mk(1, 1, 8'h09, 2'b11, 2'b10, 1, 1, 8'h02, 2'b11, 2'b10, 3'd3));
        vecs.push_back(mk(1, 0, 8'h09, 2'b11, 2'b10, 1, 0, 8'h02, 2'b11, 2'b10, 3'd4));
        vecs.push_back(mk(0, 1, 8'h00, 2'b00, 2'b00, 1, 1, 8'h03, 2'b11, 2'b10, 3'd3));
        vecs.push_back(mk(0, 1, 8'h00, 2'b00, 2'b00, 1, 1, 8'h04, 2'b11, 2'b10, 3'd2));
        vecs.push_back(mk(0, 1, 8'h00, 2'b00, 2'b00, 1, 1, 8'h09, 2'b11, 2'b10, 3'd1));
        vecs.push_back(mk(0, 1, 8'h00, 2'b00, 2'b00, 0, 1, 8'h00, 2'b00, 2'b00, 3'd0));
        vecs.push_back(mk(0, 1, 8'h00, 2'b00, 2'b00, 0, 1, 8'h00, 2'b00, 2'b00, 3'd0));

        // ---- reset state ----
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_err_count", err_count, 8'd0);
        chk("rst_out_word", out_word, 8'h00);
        #10 rst_n = 1'b1;
        tick();

        // ---- table-driven fill / full / drain ----
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid    = vecs[i].iv;
            out_ready   = vecs[i].ordy;
            conv_out    = vecs[i].word;
            conv_selin  = vecs[i].si;
            conv_selout = vecs[i].so;
            conv_err    = 1'b0;
            tick();
            chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
            chk($sformatf("v%0d_level", i), level, vecs[i].e_lvl);
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d_out_word", i), out_word, vecs[i].e_word);
                chk($sformatf("v%0d_out_selin", i), out_selin, vecs[i].e_si);
                chk($sformatf("v%0d_out_selout", i), out_selout, vecs[i].e_so);
                chk($sformatf("v%0d_out_err", i), out_err, 1'b0);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // ---- steady push+pop at level 2 across pointer wrap ----
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; conv_out = 8'hA0 + 8'(i);
            tick();
        end
        chk("stream_prefill_level", level, 3'd2);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("stream_head%0d", k), out_word, 8'hA0 + 8'(k));
            in_valid = 1'b1; out_ready = 1'b1; conv_out = 8'hA2 + 8'(k);
            tick();
            chk($sformatf("stream_level%0d", k), level, 3'd2);
        end
        in_valid = 1'b0;
        chk("stream_drain0", out_word, 8'hAA);
        tick();
        chk("stream_drain1", out_word, 8'hAB);
        tick();
        chk("stream_empty", level, 3'd0);

        // ---- error counting, clear priority, saturation at ECW=2 ----
        out_ready = 1'b1; in_valid = 1'b1; conv_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            conv_out = 8'hE0 + 8'(i);
            tick();
        end
        chk("err_count3", err_count, 8'd3);
        chk("err_count3_ecw2", err_count2, 2'd3);
`ifdef UCC_DROP_ERR_EN
        chk("err_dropped_level", level, 3'd0);
`else
        chk("err_stored_level", level, 3'd1);
        chk("err_stored_flag", out_err, 1'b1);
`endif
        clr_err = 1'b1; conv_out = 8'hE3;
        tick();
        chk("clr_wins", err_count, 8'd0);
        chk("clr_wins_ecw2", err_count2, 2'd0);
        clr_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            conv_out = 8'hE4 + 8'(i);
            tick();
        end
        chk("err_count5", err_count, 8'd5);
        chk("err_sat_ecw2", err_count2, 2'd3);
        in_valid = 1'b0; conv_err = 1'b0;
        tick();
        chk("err_drain_level", level, 3'd0);
        out_ready = 1'b0; clr_err = 1'b1;
        tick();
        chk("clr_only", err_count, 8'd0);
        clr_err = 1'b0;

        // ---- mixed good/error words ----
        in_valid = 1'b1;
        conv_out = 8'h10; conv_err = 1'b0; tick();
        conv_out = 8'h11; conv_err = 1'b1; tick();
        conv_out = 8'h12; conv_err = 1'b0; tick();
        in_valid = 1'b0;
        chk("mix_err_count", err_count, 8'd1);
`ifdef UCC_DROP_ERR_EN
        chk("mix_level", level, 3'd2);
        out_ready = 1'b1;
        chk("mix_head0", out_word, 8'h10);
        tick();
        chk("mix_head1", out_word, 8'h12);
        chk("mix_head1_err", out_err, 1'b0);
        tick();
`else
        chk("mix_level", level, 3'd3);
        out_ready = 1'b1;
        chk("mix_head0", out_word, 8'h10);
        tick();
        chk("mix_head1", out_word, 8'h11);
        chk("mix_head1_err", out_err, 1'b1);
        tick();
        chk("mix_head2", out_word, 8'h12);
        tick();
`endif
        chk("mix_empty", out_valid, 1'b0);
        out_ready = 1'b0;

        // ---- asynchronous reset mid-cycle at level 3 ----
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            conv_out = 8'h30 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_level", level, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_level", level, 3'd0);
        chk("async_rst_err_count", err_count, 8'd0);
        chk("async_rst_out_word", out_word, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_level", level, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
